// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// All display drives are active-low, so "off" is all ones.
package seven_seg_pkg;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low anode pattern for one digit slot; a disabled digit keeps every anode dark.
    function automatic logic [3:0] anode_sel(input logic en, input logic [1:0] idx);
        logic [3:0] sel;
        if (en) begin
            sel = ~(4'b0001 << idx);
        end else begin
            sel = AN_OFF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_7seg.sv
// Combinational hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Lookup of the glyph for each hex value
    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            4'hF:    seg_o = 7'b0001110;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode display scanner with a blanking gap between digits.
// Data and enable are latched once per slot so CPU writes never tear a digit.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digit_data,
    input  logic [3:0]  digit_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nib_q, nib_d;
    logic             en_q, en_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q;
    logic [6:0]       dec_s;

    // Decoding the next-state nibble keeps the registered outputs aligned with the state.
    hex_to_7seg u_dec (
        .nibble_i (nib_d),
        .seg_o    (dec_s)
    );

    // Slot sequencing: blanking gap, then the digit, then advance to the next digit
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_ONE;
        nib_d   = nib_q;
        en_d    = en_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = CNT_ZERO;
                    nib_d   = digit_data[{idx_q, 2'b00} +: 4];
                    en_d    = digit_en[idx_q];
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_ZERO;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = CNT_ZERO;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Output drive for the upcoming cycle, derived from the next state
    always_comb begin
        if (state_d == ST_SHOW) begin
            an_d  = anode_sel(en_d, idx_d);
            seg_d = dec_s;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            idx_q   <= 2'd0;
            cnt_q   <= CNT_ZERO;
            nib_q   <= 4'h0;
            en_q    <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= 1'b1;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with an 8-cycle slot (2 blank + 6 show).
module tb_seven_seg_scan;

    logic        clk;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int total;
    int bad;

    logic [6:0] tbl [16];

    seven_seg_scan #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_data (digit_data),
        .digit_en   (digit_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check n consecutive cycles of one expected an/seg pattern, advancing after each
    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input int n);
        for (int i = 0; i < n; i++) begin
            cmp({tag, "_an"}, {3'b000, an}, {3'b000, ea});
            cmp({tag, "_seg"}, seg, es);
            cmp({tag, "_dp"}, {6'b0, dp}, 7'd1);
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl[0]  = 7'b1000000; tbl[1]  = 7'b1111001; tbl[2]  = 7'b0100100; tbl[3]  = 7'b0110000;
        tbl[4]  = 7'b0011001; tbl[5]  = 7'b0010010; tbl[6]  = 7'b0000010; tbl[7]  = 7'b1111000;
        tbl[8]  = 7'b0000000; tbl[9]  = 7'b0010000; tbl[10] = 7'b0001000; tbl[11] = 7'b0000011;
        tbl[12] = 7'b1000110; tbl[13] = 7'b0100001; tbl[14] = 7'b0000110; tbl[15] = 7'b0001110;

        // Reset held for 3 cycles: outputs sit at reset values
        reset      = 1'b1;
        digit_data = 16'h1234;
        digit_en   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("rst_an", {3'b000, an}, 7'h0F);
            cmp("rst_seg", seg, 7'h7F);
            cmp("rst_dp", {6'b0, dp}, 7'd1);
        end
        reset = 1'b0;

        // Scan order 0,1,2,3 then wrap; digit 0 = nibble 4
        chk("blank0", 4'hF, 7'h7F, 2);
        chk("dig0", 4'b1110, tbl[4], 6);
        chk("blank1", 4'hF, 7'h7F, 2);
        chk("dig1", 4'b1101, tbl[3], 6);
        chk("blank2", 4'hF, 7'h7F, 2);
        chk("dig2", 4'b1011, tbl[2], 6);
        chk("blank3", 4'hF, 7'h7F, 2);
        chk("dig3", 4'b0111, tbl[1], 6);
        chk("blankw", 4'hF, 7'h7F, 2);
        chk("wrap0", 4'b1110, tbl[4], 6);

        // Enable masking: digits 1 and 3 stay dark for two full scans
        reset = 1'b1;
        step();
        reset      = 1'b0;
        digit_en   = 4'b0101;
        digit_data = 16'h8888;
        for (int r = 0; r < 2; r++) begin
            chk("m_blank0", 4'hF, 7'h7F, 2);
            chk("m_dig0", 4'b1110, tbl[8], 6);
            chk("m_blank1", 4'hF, 7'h7F, 2);
            chk("m_dig1", 4'hF, tbl[8], 6);
            chk("m_blank2", 4'hF, 7'h7F, 2);
            chk("m_dig2", 4'b1011, tbl[8], 6);
            chk("m_blank3", 4'hF, 7'h7F, 2);
            chk("m_dig3", 4'hF, tbl[8], 6);
        end

        // Decoder sweep on digit 0, data changed at the end of each digit-3 slot
        reset = 1'b1;
        step();
        reset      = 1'b0;
        digit_en   = 4'hF;
        digit_data = 16'h0000;
        for (int n = 0; n < 16; n++) begin
            chk("sw_blank", 4'hF, 7'h7F, 2);
            chk($sformatf("sweep_%0h", n), 4'b1110, tbl[n], 6);
            repeat (23) step();
            digit_data = {12'h000, 4'(n + 1)};
            step();
        end

        // Tear-free: write lands mid-slot, takes effect on the following slots
        reset = 1'b1;
        step();
        reset      = 1'b0;
        digit_data = 16'h0000;
        chk("t_blank0", 4'hF, 7'h7F, 2);
        chk("t_pre", 4'b1110, tbl[0], 3);
        digit_data = 16'hFFFF;
        chk("t_hold", 4'b1110, tbl[0], 3);
        chk("t_blank1", 4'hF, 7'h7F, 2);
        chk("t_dig1", 4'b1101, tbl[15], 6);
        chk("t_blank2", 4'hF, 7'h7F, 2);
        chk("t_dig2", 4'b1011, tbl[15], 6);
        chk("t_blank3", 4'hF, 7'h7F, 2);
        chk("t_dig3", 4'b0111, tbl[15], 6);
        chk("t_blankw", 4'hF, 7'h7F, 2);
        chk("t_next0", 4'b1110, tbl[15], 6);

        // Mid-slot reset during digit-2 show restarts at digit 0
        chk("mr_blank1", 4'hF, 7'h7F, 2);
        chk("mr_dig1", 4'b1101, tbl[15], 6);
        chk("mr_blank2", 4'hF, 7'h7F, 2);
        chk("mr_dig2", 4'b1011, tbl[15], 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmp("mr_an", {3'b000, an}, 7'h0F);
        cmp("mr_seg", seg, 7'h7F);
        cmp("mr_dp", {6'b0, dp}, 7'd1);
        chk("mr_blank0", 4'hF, 7'h7F, 2);
        chk("mr_dig0", 4'b1110, tbl[15], 6);

        // Random traffic: at most one anode low, decimal point always off
        for (int i = 0; i < 1000; i++) begin
            digit_data = 16'($urandom);
            digit_en   = 4'($urandom_range(0, 15));
            step();
            cmp("onehot", {6'b0, ($countones(~an) <= 1) ? 1'b1 : 1'b0}, 7'd1);
            cmp("rnd_dp", {6'b0, dp}, 7'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
